uart_boot_loader: RTL and testbench

//  UART program loader sitting directly upstream of the RV32E core and its unified SRAM.

---
 rtl/uart_boot_loader.sv | 209 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed image over UART, writes it to RAM word by word,
// verifies the checksum, replies 'K'/'E' and releases the core on success.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned MAX_BYTES    = 393216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_OK, S_FAIL, S_DONE} st_t;
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_t rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, sum_q, sum_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
  st_t st_q, st_d;
  logic [31:0] len_q, len_d, buf_q, buf_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [18:0] cnt_q, cnt_d, word_q, word_d;
  logic [3:0] wr_be_q, wr_be_d, tx_idx_q, tx_idx_d;
  logic wr_en_q, wr_en_d, core_rst_q, core_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic rx_ok, last, tx_end;
  logic [1:0] lane;
  logic [31:0] len_full, buf_nx;
  logic [9:0] tx_frame;
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      default: if (rx_cnt_q == BIT_END) begin
        rx_st_d = R_IDLE;
        rx_valid_d = 1'b1;
        rx_ferr_d = !rx_s2_q;
      end
    endcase
  end
  assign rx_ok = rx_valid_q && !rx_ferr_q;
  assign lane = cnt_q[1:0];
  assign last = ({13'd0, cnt_q} + 32'd1) == len_q;
  assign len_full = {rx_sh_q, len_q[31:8]};
  assign buf_nx = (lane == 2'd0) ? {24'd0, rx_sh_q} : buf_q | ({24'd0, rx_sh_q} << {lane, 3'b000});
  assign tx_frame = {1'b1, (st_q == S_OK) ? 8'h4B : 8'h45, 1'b0};
  assign tx_end = (tx_idx_q == 4'd9) && (tx_cnt_q == BIT_END);
  always_comb begin
    st_d = st_q;
    len_d = len_q;
    cnt_d = cnt_q;
    word_d = word_q;
    sum_d = sum_q;
    buf_d = buf_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d = wr_be_q;
    core_rst_d = core_rst_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    tx_cnt_d = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + 16'd1;
    tx_idx_d = (tx_cnt_q == BIT_END) ? tx_idx_q + 4'd1 : tx_idx_q;
    case (st_q)
      S_IDLE: if (rx_ok && rx_sh_q == 8'hA5) begin
        st_d = S_LEN;
        err_d = 1'b0;
        busy_d = 1'b1;
        sum_d = '0;
        cnt_d = '0;
      end
      S_LEN: if (rx_ok) begin
        len_d = len_full;
        cnt_d = cnt_q + 19'd1;
        if (cnt_q == 19'd3) begin
          cnt_d = '0;
          word_d = '0;
          st_d = (len_full > MAX_BYTES) ? S_FAIL : (len_full == 32'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: if (rx_ok) begin
        buf_d = buf_nx;
        cnt_d = cnt_q + 19'd1;
        sum_d = sum_q + rx_sh_q;
        if (lane == 2'd3 || last) begin
          wr_en_d = 1'b1;
          wr_addr_d = BASE_ADDR + {11'd0, word_q, 2'b00};
          wr_data_d = buf_nx;
          wr_be_d = {lane == 2'd3, lane >= 2'd2, lane != 2'd0, 1'b1};
          word_d = word_q + 19'd1;
        end
        if (last) st_d = S_CSUM;
      end
      S_CSUM: if (rx_ok) st_d = (rx_sh_q == sum_q) ? S_OK : S_FAIL;
      S_OK: if (tx_end) begin
        st_d = S_DONE;
        done_d = 1'b1;
        core_rst_d = 1'b0;
        busy_d = 1'b0;
      end
      S_FAIL: if (tx_end) begin
        st_d = S_IDLE;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    // a broken stop bit mid-frame aborts the load
    if (rx_valid_q && rx_ferr_q && (st_q == S_LEN || st_q == S_DATA || st_q == S_CSUM)) st_d = S_FAIL;
    if (st_d != st_q && (st_d == S_OK || st_d == S_FAIL)) begin
      tx_cnt_d = '0;
      tx_idx_d = '0;
      err_d = err_d | (st_d == S_FAIL);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q <= R_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      st_q <= S_IDLE;
      len_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      sum_q <= '0;
      buf_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q <= '0;
      core_rst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q <= rx_ferr_d;
      st_q <= st_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      sum_q <= sum_d;
      buf_q <= buf_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q <= wr_be_d;
      core_rst_q <= core_rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
    end
  end
  assign uart_tx = (st_q == S_OK || st_q == S_FAIL) ? tx_frame[tx_idx_q] : 1'b1;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be = wr_be_q;
  assign core_rst = core_rst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives UART frames and checks RAM writes, status byte and flags against a frame-level model.
module tb_uart_boot_loader;
  localparam int CPB = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned MAXB = 393216;
  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic uart_tx, wr_en, core_rst, busy, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [3:0] wr_be;
  int checks = 0, errors = 0;
  logic [31:0] wa_q[$], wd_q[$];
  logic [3:0] wb_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] tx_b;
  uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .core_rst(core_rst),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (wr_en) begin
    wa_q.push_back(wr_addr);
    wd_q.push_back(wr_data);
    wb_q.push_back(wr_be);
  end
  initial forever begin
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        tx_b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check("tx_stop", uart_tx, 1'b1);
      tx_q.push_back(tx_b);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    wb_q.delete();
    tx_q.delete();
  endtask
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_wr_be", wr_be, 4'h0);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  // bad >= 0 sends payload byte 'bad' with its stop bit low and ends the frame there
  task automatic run_frame(input logic [31:0] len, input logic [7:0] pl[$], input logic [7:0] cs, input int bad);
    int n, nb;
    bit ok;
    logic [7:0] sum;
    logic [31:0] ea[$], ed[$], d;
    logic [3:0] eb[$];
    clear_q();
    send_byte(8'hA5, 1'b1);
    check("busy_set", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
    if (len <= MAXB) begin
      for (int i = 0; i < len; i++) begin
        send_byte(pl[i], i != bad);
        if (i == bad) break;
      end
      if (bad < 0) send_byte(cs, 1'b1);
    end
    for (int i = 0; i < 30 * CPB && busy; i++) @(negedge clk);
    check("busy_clear", busy, 1'b0);
    n = (len > MAXB) ? 0 : (bad >= 0) ? bad : int'(len);
    sum = 8'h0;
    for (int i = 0; i < n; i++) sum += pl[i];
    ok = (len <= MAXB) && (bad < 0) && (sum == cs);
    for (int w = 0; w * 4 < n; w++) begin
      nb = (n - 4 * w > 4) ? 4 : n - 4 * w;
      if (nb < 4 && bad >= 0) break;
      d = 32'h0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = pl[4*w + k];
      ea.push_back(BASE + 32'(4 * w));
      ed.push_back(d);
      eb.push_back(4'((5'b1 << nb) - 5'd1));
    end
    check("wr_count", wa_q.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
      check("wr_addr", wa_q[i], ea[i]);
      check("wr_data", wd_q[i], ed[i]);
      check("wr_be", wb_q[i], eb[i]);
    end
    check("tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("tx_byte", tx_q[0], ok ? 8'h4B : 8'h45);
    check("done", done, ok);
    check("err", err, !ok);
    check("core_rst", core_rst, !ok);
  endtask
  initial begin
    logic [7:0] p8[$], p5[$], pr[$], none[$];
    logic [7:0] s;
    logic [31:0] len;
    int bad;
    p8 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    p5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (3) @(negedge clk);
    do_reset();
    clear_q();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("stray_tx", tx_q.size(), 0);
    check("stray_busy", busy, 1'b0);
    check("stray_wr", wa_q.size(), 0);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("glitch_busy", busy, 1'b0);
    run_frame(32'h0006_0001, none, 8'h00, -1);
    run_frame(32'd8, p8, 8'h25, -1);
    run_frame(32'd8, p8, 8'h24, 4);
    run_frame(32'd8, p8, 8'h24, -1);
    do_reset();
    run_frame(32'd5, p5, 8'hFF, -1);
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h08, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    do_reset();
    run_frame(32'd8, p8, 8'h24, -1);
    clear_q();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (12 * CPB) @(negedge clk);
    check("post_done_busy", busy, 1'b0);
    check("post_done_tx", tx_q.size(), 0);
    check("post_done_wr", wa_q.size(), 0);
    check("post_done_core_rst", core_rst, 1'b0);
    check("post_done_done", done, 1'b1);
    for (int it = 0; it < 6; it++) begin
      do_reset();
      len = 32'($urandom_range(0, 11));
      pr.delete();
      s = 8'h0;
      for (int i = 0; i < len; i++) begin
        pr.push_back(8'($urandom));
        s += pr[i];
      end
      bad = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      if ($urandom_range(0, 1) == 0) s += 8'($urandom_range(1, 255));
      run_frame(len, pr, s, bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
